fb_rect_fill: RTL and testbench



---
 rtl/fb_pkg.sv | 23 ++
 rtl/rect_normalize_clip.sv | 44 ++++
 rtl/fb_rect_fill.sv | 157 +++++++++++++++
 tb/tb_fb_rect_fill.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the grayscale framebuffer and its drawing
// engines.
//   H_RES, V_RES   visible area in pixels / lines
//   COORD_W, PIX_W coordinate and grayscale pixel widths
//   coord_t, pix_t coordinate and pixel types
//   fill_state_t   fill engine states
package fb_pkg;

    localparam int unsigned H_RES   = 640;
    localparam int unsigned V_RES   = 480;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned PIX_W   = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [PIX_W-1:0]   pix_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/rect_normalize_clip.sv
// rect_normalize_clip: combinational corner normalisation and clipping.
//   x0, y0, x1, y1  in   rectangle corners, inclusive, any order
//   clear           in   select the full visible area instead of the corners
//   xa, ya          out  top-left corner (minimum of each axis)
//   xb, yb          out  bottom-right corner, clipped to H_RES-1 / V_RES-1
//   offscreen       out  rectangle lies entirely outside the visible area
module rect_normalize_clip #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned COORD_W = 11
) (
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               clear,
    output logic [COORD_W-1:0] xa,
    output logic [COORD_W-1:0] xb,
    output logic [COORD_W-1:0] ya,
    output logic [COORD_W-1:0] yb,
    output logic               offscreen
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

    always_comb begin
        xa        = '0;
        ya        = '0;
        xb        = X_MAX;
        yb        = Y_MAX;
        offscreen = 1'b0;
        if (!clear) begin
            xa = (x0 < x1) ? x0 : x1;
            xb = (x0 < x1) ? x1 : x0;
            ya = (y0 < y1) ? y0 : y1;
            yb = (y0 < y1) ? y1 : y0;
            if (xb > X_MAX) xb = X_MAX;
            if (yb > Y_MAX) yb = Y_MAX;
            offscreen = (xa > X_MAX) || (ya > Y_MAX);
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// fb_rect_fill: rectangle / full-screen fill engine feeding the framebuffer
// write port, one pixel per clock in row-major order.
//   CLOCK_50        in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   start           in   rectangle command strobe (ignored while busy)
//   clear           in   full-screen fill strobe, wins over start
//   abort           in   stop the current fill without a done pulse
//   x0, y0, x1, y1  in   rectangle corners, inclusive, any order
//   shade           in   fill value
//   x, y            out  framebuffer write coordinate
//   pixel_GS        out  framebuffer write data (latched shade)
//   pixel_write     out  framebuffer write strobe
//   busy            out  command in progress
//   done            out  one-cycle completion pulse
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int unsigned H_RES   = fb_pkg::H_RES,
    parameter int unsigned V_RES   = fb_pkg::V_RES,
    parameter int unsigned COORD_W = fb_pkg::COORD_W,
    parameter int unsigned PIX_W   = fb_pkg::PIX_W
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic               clear,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [PIX_W-1:0]   shade,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [PIX_W-1:0]   pixel_GS,
    output logic               pixel_write,
    output logic               busy,
    output logic               done
);

    fill_state_t        state, state_n;
    logic [COORD_W-1:0] xa_r, xb_r, yb_r;
    logic [COORD_W-1:0] xa_n, xb_n, yb_n;
    logic [COORD_W-1:0] x_n, y_n;
    logic [PIX_W-1:0]   pix_n;
    logic               write_n, busy_n, done_n;

    logic [COORD_W-1:0] nc_xa, nc_xb, nc_ya, nc_yb;
    logic               nc_off;

    rect_normalize_clip #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .COORD_W(COORD_W)
    ) u_norm (
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .clear    (clear),
        .xa       (nc_xa),
        .xb       (nc_xb),
        .ya       (nc_ya),
        .yb       (nc_yb),
        .offscreen(nc_off)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            xa_r        <= '0;
            xb_r        <= '0;
            yb_r        <= '0;
            x           <= '0;
            y           <= '0;
            pixel_GS    <= '0;
            pixel_write <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            xa_r        <= xa_n;
            xb_r        <= xb_n;
            yb_r        <= yb_n;
            x           <= x_n;
            y           <= y_n;
            pixel_GS    <= pix_n;
            pixel_write <= write_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        xa_n    = xa_r;
        xb_n    = xb_r;
        yb_n    = yb_r;
        x_n     = x;
        y_n     = y;
        pix_n   = pixel_GS;
        write_n = 1'b0;
        busy_n  = busy;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (clear || start) begin
                    xa_n    = nc_xa;
                    xb_n    = nc_xb;
                    yb_n    = nc_yb;
                    pix_n   = shade;
                    busy_n  = 1'b1;
                    // An off-screen rectangle spends one write-less cycle in
                    // FILL so its done pulse lands one cycle later, exactly
                    // like the cycle after a final write.
                    state_n = FILL;
                    if (!nc_off) begin
                        x_n     = nc_xa;
                        y_n     = nc_ya;
                        write_n = 1'b1;
                    end
                end
            end

            FILL: begin
                if (abort) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (!pixel_write || (x == xb_r && y == yb_r)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    write_n = 1'b1;
                    if (x == xb_r) begin
                        x_n = xa_r;
                        y_n = y + COORD_W'(1);
                    end else begin
                        x_n = x + COORD_W'(1);
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: randomized and directed self-checking bench for
// fb_rect_fill. The DUT runs at a reduced resolution so a full-screen clear
// stays short; clip/off-screen cases are placed at that resolution's edges.
module tb_fb_rect_fill;

    localparam int unsigned TB_H = 160;
    localparam int unsigned TB_V = 120;
    localparam int unsigned CW   = 11;
    localparam int unsigned PW   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, clear, abort;
    logic [CW-1:0] x0, y0, x1, y1;
    logic [PW-1:0] shade;
    logic [CW-1:0] x, y;
    logic [PW-1:0] pixel_GS;
    logic          pixel_write, busy, done;

    int checks   = 0;
    int failures = 0;

    fb_rect_fill #(
        .H_RES  (TB_H),
        .V_RES  (TB_V),
        .COORD_W(CW),
        .PIX_W  (PW)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .abort      (abort),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .shade      (shade),
        .x          (x),
        .y          (y),
        .pixel_GS   (pixel_GS),
        .pixel_write(pixel_write),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Issues one command and checks every cycle of its lifetime against a
    // list of pixels built directly from the corner/clip rules.
    //   abort_at  : abort sampled at edge E<abort_at> (-1 = never)
    //   start_mid : pulse a competing start after edge E<start_mid> (-1 = never)
    task automatic run_cmd(input bit do_clear, input bit do_start,
                           input int ax0, input int ay0, input int ax1, input int ay1,
                           input int sh, input int abort_at, input int start_mid);
        int qx[$];
        int qy[$];
        int xa, xb, ya, yb, n, d;
        bit off;

        if (do_clear) begin
            xa = 0; ya = 0; xb = TB_H - 1; yb = TB_V - 1; off = 0;
        end else begin
            xa = (ax0 < ax1) ? ax0 : ax1;
            xb = (ax0 < ax1) ? ax1 : ax0;
            ya = (ay0 < ay1) ? ay0 : ay1;
            yb = (ay0 < ay1) ? ay1 : ay0;
            if (xb > TB_H - 1) xb = TB_H - 1;
            if (yb > TB_V - 1) yb = TB_V - 1;
            off = (xa > TB_H - 1) || (ya > TB_V - 1);
        end
        if (!off)
            for (int yy = ya; yy <= yb; yy++)
                for (int xx = xa; xx <= xb; xx++) begin
                    qx.push_back(xx);
                    qy.push_back(yy);
                end
        n = qx.size();
        d = (n == 0) ? 1 : n;

        x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
        shade = PW'(sh);
        clear = do_clear;
        start = do_start;
        @(posedge clk); #1;
        clear = 1'b0;
        start = 1'b0;

        for (int k = 0; k <= d + 1; k++) begin
            if (abort_at >= 0 && k == abort_at) begin
                abort = 1'b0;
                check_val("abort_pw", int'(pixel_write), 0);
                check_val("abort_busy", int'(busy), 0);
                check_val("abort_done", int'(done), 0);
                for (int j = 0; j < 3; j++) begin
                    @(posedge clk); #1;
                    check_val("abort_nodone", int'(done), 0);
                    check_val("abort_idle_pw", int'(pixel_write), 0);
                end
                return;
            end
            if (k < n) begin
                check_val("wr_pw", int'(pixel_write), 1);
                check_val("wr_x", int'(x), qx[k]);
                check_val("wr_y", int'(y), qy[k]);
                check_val("wr_pix", int'(pixel_GS), sh);
                check_val("wr_busy", int'(busy), 1);
                check_val("wr_done", int'(done), 0);
            end else if (k < d) begin
                check_val("off_pw", int'(pixel_write), 0);
                check_val("off_busy", int'(busy), 1);
                check_val("off_done", int'(done), 0);
            end else if (k == d) begin
                check_val("done_pw", int'(pixel_write), 0);
                check_val("done_busy", int'(busy), 1);
                check_val("done_pulse", int'(done), 1);
            end else begin
                check_val("idle_pw", int'(pixel_write), 0);
                check_val("idle_busy", int'(busy), 0);
                check_val("idle_done", int'(done), 0);
            end
            abort = (abort_at >= 0 && k + 1 == abort_at);
            if (k == start_mid) begin
                x0 = CW'(1); y0 = CW'(1); x1 = CW'(2); y1 = CW'(2);
                shade = PW'(sh ^ 8'hFF);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k < d + 1) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        reset = 1'b1;
        start = 1'b0; clear = 1'b0; abort = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; shade = '0;
        #12;
        check_val("rst_out", int'({x, y, pixel_GS, pixel_write, busy, done}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_cmd(0, 1, 4, 0, 5, 2, 127, -1, -1);
        run_cmd(0, 1, 9, 7, 8, 6, 33, -1, -1);
        run_cmd(0, 1, TB_H - 4, TB_V - 2, 700, 900, 255, -1, -1);
        run_cmd(0, 1, TB_H + 10, 5, TB_H + 10, 9, 77, -1, -1);
        run_cmd(0, 1, 3, TB_V + 1, 3, TB_V + 5, 78, -1, -1);
        run_cmd(0, 1, 12, 12, 12, 12, 9, -1, -1);
        run_cmd(1, 1, 2, 2, 3, 3, 0, -1, 100);
        run_cmd(0, 1, 10, 10, 19, 19, 200, 3, -1);

        // Abort while idle must not disturb the next command.
        abort = 1'b1;
        @(posedge clk); #1;
        check_val("idle_abort_busy", int'(busy), 0);
        abort = 1'b0;
        run_cmd(0, 1, 7, 3, 7, 5, 66, -1, -1);

        for (int i = 0; i < 10; i++) begin
            rx0 = $urandom_range(TB_H + 6, 0);
            ry0 = $urandom_range(TB_V + 6, 0);
            rx1 = rx0 + $urandom_range(12, 0) - 6;
            ry1 = ry0 + $urandom_range(12, 0) - 6;
            if (rx1 < 0) rx1 = 0;
            if (ry1 < 0) ry1 = 0;
            run_cmd(0, 1, rx0, ry0, rx1, ry1, int'($urandom_range(255, 0)), -1, -1);
        end

        // Reset in the middle of a fill, then a fresh command.
        x0 = CW'(0); y0 = CW'(0); x1 = CW'(9); y1 = CW'(9); shade = PW'(50);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_val("pre_rst_pw", int'(pixel_write), 1);
        reset = 1'b1;
        #1;
        check_val("midrst_out", int'({x, y, pixel_GS, pixel_write, busy, done}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_busy", int'(busy), 0);
        run_cmd(0, 1, 4, 0, 5, 2, 127, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
